// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV64 MEM stage load/store unit with dmem handshake and MEM/WB register
//
// Sits between the EX/MEM and MEM/WB pipeline registers. Loads and stores
// are issued to data memory over a req/ack handshake; the pipeline is
// stalled while an access is outstanding.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_valid          EX/MEM holds a valid instruction
//   ex_is_load        instruction is a load
//   ex_is_store       instruction is a store
//   ex_reg_write      instruction writes rd
//   ex_func3          access size / signedness
//   ex_rd             destination register
//   ex_result         ALU result, effective address for loads/stores
//   ex_wdata          store data (rs2)
//   stall             freeze IF/ID/EX and hold EX/MEM
//   dmem_req          memory request valid
//   dmem_we           1 = write
//   dmem_addr         doubleword-aligned address
//   dmem_wdata        lane-replicated store data
//   dmem_wstrb        byte strobes
//   dmem_ack          request complete; dmem_rdata valid in the same cycle
//   dmem_rdata        read doubleword
//   wb_valid          MEM/WB payload valid (one cycle per instruction)
//   wb_we             register write enable
//   wb_rd             destination register
//   wb_data           load data or passed-through ex_result
//   exc_misalign      misaligned access pulse (with wb_valid)
//   exc_bus           timeout / illegal func3 pulse (with wb_valid)

module mem_stage_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic            ex_reg_write,
  input  logic [2:0]      ex_func3,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_wdata,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_misalign,
  output logic            exc_bus
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Context of the outstanding access, captured on entry to ACCESS.
  logic [2:0]       req_f3;
  logic [2:0]       req_off;
  logic [4:0]       req_rd;
  logic             req_wr;
  logic             req_load;

  // ---------------------------------------------------------------
  // EX/MEM decode
  // ---------------------------------------------------------------
  logic       is_mem;
  logic       f3_illegal;
  logic       misalign;
  logic       accept;
  logic [2:0] off;
  logic [1:0] sz;

  assign is_mem = ex_is_load | ex_is_store;
  assign off    = ex_result[2:0];
  assign sz     = ex_func3[1:0];

  // Loads only reject 111; stores have no unsigned variants, so any 1xx is illegal.
  assign f3_illegal = ex_is_load ? (ex_func3 == 3'b111) : ex_func3[2];

  always_comb begin
    misalign = 1'b0;
    case (sz)
      2'd1:    misalign = off[0];
      2'd2:    misalign = |off[1:0];
      2'd3:    misalign = |off;
      default: misalign = 1'b0;
    endcase
  end

  assign accept = (state == S_IDLE) && ex_valid && is_mem && !f3_illegal && !misalign;

  // Stall covers the accept cycle (combinational) through the ack cycle.
  assign stall = !rst && ((state == S_ACCESS) || accept);

  // ---------------------------------------------------------------
  // Store lane formatting
  // ---------------------------------------------------------------
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      st_wstrb;

  always_comb begin
    st_wdata = ex_wdata;
    st_wstrb = 8'hFF;
    case (sz)
      2'd0: begin
        st_wdata = {8{ex_wdata[7:0]}};
        st_wstrb = 8'h01 << off;
      end
      2'd1: begin
        st_wdata = {4{ex_wdata[15:0]}};
        st_wstrb = 8'h03 << off;
      end
      2'd2: begin
        st_wdata = {2{ex_wdata[31:0]}};
        st_wstrb = 8'h0F << off;
      end
      default: begin
        st_wdata = ex_wdata;
        st_wstrb = 8'hFF;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Load lane select and extension
  // ---------------------------------------------------------------
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_data;

  // Shift the addressed byte lane down to bit 0 before extending.
  assign lane = dmem_rdata >> {req_off, 3'b000};

  always_comb begin
    ld_data = lane;
    case (req_f3)
      3'b000:  ld_data = {{56{lane[7]}},  lane[7:0]};
      3'b001:  ld_data = {{48{lane[15]}}, lane[15:0]};
      3'b010:  ld_data = {{32{lane[31]}}, lane[31:0]};
      3'b100:  ld_data = {56'd0, lane[7:0]};
      3'b101:  ld_data = {48'd0, lane[15:0]};
      3'b110:  ld_data = {32'd0, lane[31:0]};
      default: ld_data = lane;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM, request registers and MEM/WB register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= 8'h00;
      req_f3       <= 3'd0;
      req_off      <= 3'd0;
      req_rd       <= 5'd0;
      req_wr       <= 1'b0;
      req_load     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
    end else begin
      // MEM/WB payload is a one-cycle pulse unless set below.
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= '0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= ex_reg_write && (ex_rd != 5'd0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_result;
            end else if (f3_illegal) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              exc_bus  <= 1'b1;
            end else if (misalign) begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              exc_misalign <= 1'b1;
            end else begin
              state      <= S_ACCESS;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= !ex_is_load;
              dmem_addr  <= {ex_result[XLEN-1:3], 3'b000};
              dmem_wdata <= ex_is_load ? '0 : st_wdata;
              dmem_wstrb <= ex_is_load ? 8'h00 : st_wstrb;
              req_f3     <= ex_func3;
              req_off    <= off;
              req_rd     <= ex_rd;
              req_wr     <= ex_reg_write && (ex_rd != 5'd0);
              req_load   <= ex_is_load;
            end
          end
        end

        S_ACCESS: begin
          if (dmem_ack) begin
            state    <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= req_rd;
            wb_we    <= req_load && req_wr;
            wb_data  <= req_load ? ld_data : '0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // This wait cycle brings the count to TIMEOUT: abandon the access.
            state    <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= req_rd;
            exc_bus  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard testbench for mem_stage_lsu

module tb_mem_stage_lsu;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_is_load, ex_is_store, ex_reg_write;
  logic [2:0]      ex_func3;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result, ex_wdata;
  logic            stall, dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic [7:0]      dmem_wstrb;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            wb_valid, wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            exc_misalign, exc_bus;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_reg_write(ex_reg_write), .ex_func3(ex_func3), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_wdata(ex_wdata),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        chk;
    logic        mis;
    logic        bus;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        chk_w;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  req_exp_t cur_req;
  wb_exp_t  mon_e;
  logic     prev_req = 1'b0;
  int       total = 0;
  int       bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-level arithmetic on the access size.
  function automatic logic [63:0] size_mask(input int n);
    if (n >= 8) return '1;
    return (64'd1 << (8 * n)) - 64'd1;
  endfunction

  function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rdata);
    int          n;
    int          off;
    logic [63:0] m;
    logic [63:0] v;
    n   = 1 << f3[1:0];
    off = int'(addr % 8);
    m   = size_mask(n);
    v   = (rdata >> (8 * off)) & m;
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] store_data_model(input logic [2:0] f3, input logic [63:0] wd);
    int          n;
    logic [63:0] pat;
    logic [63:0] r;
    n   = 1 << f3[1:0];
    pat = wd & size_mask(n);
    r   = '0;
    for (int i = 0; i < 8 / n; i++) r = r | (pat << (8 * n * i));
    return r;
  endfunction

  function automatic logic [7:0] store_strb_model(input logic [2:0] f3, input logic [63:0] addr);
    int          n;
    logic [15:0] t;
    n = 1 << f3[1:0];
    t = ((16'd1 << n) - 16'd1) << int'(addr % 8);
    return t[7:0];
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result or a new request.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got wb_valid=1 expected no result");
        end else begin
          mon_e = wb_q.pop_front();
          check("wb_we", wb_we, mon_e.we);
          check("exc_misalign", exc_misalign, mon_e.mis);
          check("exc_bus", exc_bus, mon_e.bus);
          if (mon_e.chk) begin
            check("wb_rd", wb_rd, mon_e.rd);
            check("wb_data", wb_data, mon_e.data);
          end
        end
      end else begin
        check("exc_without_wb", {exc_misalign, exc_bus}, 2'b00);
      end

      if (dmem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got dmem_req=1 expected no request");
        end else begin
          cur_req = req_q.pop_front();
          check("dmem_addr", dmem_addr, cur_req.addr);
          check("dmem_we", dmem_we, cur_req.we);
          if (cur_req.chk_w) begin
            check("dmem_wdata", dmem_wdata, cur_req.wdata);
            check("dmem_wstrb", dmem_wstrb, cur_req.wstrb);
          end
        end
      end else if (dmem_req) begin
        check("dmem_addr_stable", dmem_addr, cur_req.addr);
        check("dmem_we_stable", dmem_we, cur_req.we);
        if (cur_req.chk_w) begin
          check("dmem_wdata_stable", dmem_wdata, cur_req.wdata);
          check("dmem_wstrb_stable", dmem_wstrb, cur_req.wstrb);
        end
      end
    end
    prev_req = dmem_req;
  end

  // Random EX/MEM contents while an access is outstanding; they must be ignored.
  task automatic scramble();
    ex_valid     = 1'b1;
    ex_is_load   = 1'($urandom);
    ex_is_store  = 1'($urandom);
    ex_reg_write = 1'($urandom);
    ex_func3     = 3'($urandom);
    ex_rd        = 5'($urandom);
    ex_result    = {$urandom, $urandom};
    ex_wdata     = {$urandom, $urandom};
    dmem_rdata   = {$urandom, $urandom};
  endtask

  // One instruction; n = ACCESS cycles up to and including the ack, 0 = never ack.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                       input bit rw, input logic [63:0] addr, input logic [63:0] wd,
                       input int n, input logic [63:0] rdata);
    int       nb;
    int       cyc;
    bit       mem, illegal, mis, acc;
    wb_exp_t  e;
    req_exp_t r;
    nb      = 1 << f3[1:0];
    mem     = ld || st;
    illegal = ld ? (f3 == 3'b111) : (st && f3[2]);
    mis     = mem && !illegal && ((addr % nb) != 0);
    acc     = mem && !illegal && !mis;

    e.we = 1'b0; e.rd = rd; e.data = '0; e.chk = 1'b0; e.mis = 1'b0; e.bus = 1'b0;
    if (!mem) begin
      e.we = rw && (rd != 0); e.data = addr; e.chk = 1'b1;
    end else if (illegal) begin
      e.bus = 1'b1;
    end else if (mis) begin
      e.mis = 1'b1;
    end else if (n == 0) begin
      e.bus = 1'b1;
    end else if (ld) begin
      e.we = rw && (rd != 0); e.data = load_model(f3, addr, rdata); e.chk = 1'b1;
    end
    wb_q.push_back(e);

    if (acc) begin
      r.we    = !ld;
      r.addr  = addr & ~64'd7;
      r.wdata = ld ? '0 : store_data_model(f3, wd);
      r.wstrb = ld ? 8'h00 : store_strb_model(f3, addr);
      r.chk_w = !ld;
      req_q.push_back(r);
    end

    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_reg_write = rw;
    ex_func3 = f3; ex_rd = rd; ex_result = addr; ex_wdata = wd;
    #1 check("stall_issue", stall, acc);
    @(posedge clk); #1;

    if (acc && n == 0) begin
      cyc = 0;
      while (dmem_req && cyc < 400) begin
        scramble();
        check("stall_wait", stall, 1'b1);
        @(posedge clk); #1;
        cyc++;
      end
      check("timeout_req_cycles", cyc, TIMEOUT);
    end else if (acc) begin
      for (int c = 1; c <= n; c++) begin
        scramble();
        if (c == n) dmem_rdata = rdata;
        dmem_ack = (c == n);
        #1 check("stall_access", stall, 1'b1);
        @(posedge clk); #1;
      end
    end

    ex_valid = 1'b0;
    dmem_ack = 1'b0;
    #1 check("stall_after", stall, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] rdata;
    int          kind;
    int          nb;
    bit          ld, st;
    req_exp_t    r;

    rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_reg_write = 1'b0; ex_func3 = 3'd0; ex_rd = 5'd0; ex_result = '0; ex_wdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_exc", {exc_misalign, exc_bus}, 2'b00);
    check("rst_dmem_wstrb", dmem_wstrb, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    issue(0, 0, 3'b000, 5'd5, 1, 64'h1234, 64'd0, 1, 64'd0);
    issue(0, 0, 3'b011, 5'd0, 1, 64'hDEAD, 64'd0, 1, 64'd0);
    issue(1, 0, 3'b000, 5'd7, 1, 64'h1003, 64'd0, 3, 64'h0000_0000_8000_0000);
    issue(1, 0, 3'b110, 5'd8, 1, 64'h2004, 64'd0, 1, 64'h8765_4321_0000_0000);
    issue(1, 0, 3'b010, 5'd9, 1, 64'h2004, 64'd0, 2, 64'h8765_4321_0000_0000);
    issue(0, 1, 3'b001, 5'd3, 1, 64'h3006, 64'hABCD, 2, 64'd0);
    issue(0, 1, 3'b000, 5'd3, 0, 64'h3005, 64'h12, 1, 64'd0);
    issue(0, 1, 3'b011, 5'd3, 0, 64'h3008, 64'h0123_4567_89AB_CDEF, 1, 64'd0);
    issue(1, 0, 3'b011, 5'd4, 1, 64'h3010, 64'd0, 1, 64'hFEDC_BA98_7654_3210);
    issue(1, 0, 3'b010, 5'd6, 1, 64'h4002, 64'd0, 1, 64'd0);
    issue(1, 0, 3'b111, 5'd6, 1, 64'h4000, 64'd0, 1, 64'd0);
    issue(0, 1, 3'b101, 5'd6, 0, 64'h4000, 64'd0, 1, 64'd0);
    issue(1, 0, 3'b011, 5'd10, 1, 64'h5000, 64'd0, 0, 64'd0);

    // Reset during ACCESS: request drops, a late ack produces nothing.
    r.we = 1'b0; r.addr = 64'h6008; r.wdata = '0; r.wstrb = 8'h00; r.chk_w = 1'b0;
    req_q.push_back(r);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_reg_write = 1'b1;
    ex_func3 = 3'b011; ex_rd = 5'd11; ex_result = 64'h6008;
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    ex_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_req", dmem_req, 1'b0);
    check("rst_mid_stall", stall, 1'b0);
    check("rst_mid_wb", wb_valid, 1'b0);
    rst = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_wb", wb_valid, 1'b0);
    @(posedge clk); #1;

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      ld   = (kind < 4);
      st   = (kind >= 4) && (kind < 8);
      f3   = 3'($urandom);
      if (st && ($urandom_range(0, 3) != 0)) f3[2] = 1'b0;
      nb   = 1 << f3[1:0];
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(nb) - 64'd1);
      rdata = {$urandom, $urandom};
      issue(ld, st, f3, 5'($urandom), 1'($urandom), addr, {$urandom, $urandom},
            $urandom_range(1, 5), rdata);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("wb_q_empty", wb_q.size(), 0);
    check("req_q_empty", req_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
